i2c_target: RTL and testbench

I2C_TARGET -- requirements
Module: i2c_target

---
 rtl/i2c_target_pkg.sv | 26 ++
 rtl/i2c_line_sync.sv | 43 ++++
 rtl/i2c_target.sv | 272 +++++++++++++++++++++++++++
 tb/tb_i2c_target.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_target_pkg.sv
// i2c_target_pkg: shared definitions for the I2C target register block.
// Holds the protocol state enumeration and the default bus address.
package i2c_target_pkg;

   localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h3C;
   localparam int         DEFAULT_NREGS    = 16;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_PTR,
      ST_PTR_ACK,
      ST_WDATA,
      ST_WDATA_ACK,
      ST_RDATA,
      ST_RDATA_ACK,
      ST_IGNORE
   } i2c_state_e;

   // States in which the master shifts a byte into the block.
   function automatic logic is_rx_state(input i2c_state_e s);
      return (s == ST_ADDR) || (s == ST_PTR) || (s == ST_WDATA);
   endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: brings one raw I2C pad line into the clk domain.
// Two-flop synchronizer, reset to the idle-high bus level.
// Build macro I2C_TARGET_GLITCH_FILTER_EN appends a 3-sample majority
// filter that adds two cycles of latency and swallows 1-clk pulses.
module i2c_line_sync (
   input  logic clk,
   input  logic reset,
   input  logic line_in,
   output logic line_out
);

   logic [1:0] sync_ff;

   // Two-flop synchronizer; the bus idles high, so reset to 1.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_ff <= 2'b11;
      end else begin
         sync_ff <= {sync_ff[0], line_in};
      end
   end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
   logic [1:0] hist;
   logic       filt;

   // Majority of the last three synchronized samples, registered.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hist <= 2'b11;
         filt <= 1'b1;
      end else begin
         hist <= {hist[0], sync_ff[1]};
         filt <= (sync_ff[1] & hist[0]) | (sync_ff[1] & hist[1]) | (hist[0] & hist[1]);
      end
   end

   assign line_out = filt;
`else
   assign line_out = sync_ff[1];
`endif

endmodule

// File: rtl/i2c_target.sv
// i2c_target: I2C target exposing an NREGS x 8 register file.
// The bus writes a pointer then data bytes, or reads bytes from the pointer;
// the host side reads the file with one-cycle latency and sees each bus
// write as a wr_strobe pulse.
// Build macro I2C_TARGET_GLITCH_FILTER_EN enables line glitch filtering.
module i2c_target
   import i2c_target_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR = DEFAULT_DEV_ADDR,
   parameter int         NREGS    = DEFAULT_NREGS
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     scl_in,
   input  logic                     sda_in,
   output logic                     sda_oe,
   input  logic [$clog2(NREGS)-1:0] host_raddr,
   output logic [7:0]               host_rdata,
   output logic                     wr_strobe,
   output logic [$clog2(NREGS)-1:0] wr_addr,
   output logic [7:0]               wr_data,
   output logic                     busy
);

   localparam int ADDR_W = $clog2(NREGS);

   i2c_state_e        state, state_next;

   logic              scl_s, sda_s;
   logic              scl_q, sda_q;
   logic              scl_rise, scl_fall;
   logic              start_det, stop_det;

   logic [3:0]        bit_cnt;
   logic              byte_done;
   logic [7:0]        rx_shift;
   logic [6:0]        tx_shift;
   logic [ADDR_W-1:0] ptr;
   logic [ADDR_W-1:0] ptr_inc;
   logic              addr_match;
   logic              rw_bit;

   logic [7:0]        regs [NREGS];
   logic [7:0]        rd_cur, rd_next;

   logic              sda_oe_next;
   logic              busy_next;
   logic              rx_bit, tx_bit, clr_cnt;
   logic              load_ptr, inc_ptr;
   logic              load_tx, shift_tx;
   logic [7:0]        tx_load;
   logic              do_write;

   i2c_line_sync u_scl_sync (
      .clk      (clk),
      .reset    (reset),
      .line_in  (scl_in),
      .line_out (scl_s)
   );

   i2c_line_sync u_sda_sync (
      .clk      (clk),
      .reset    (reset),
      .line_in  (sda_in),
      .line_out (sda_s)
   );

   // Previous synchronized line levels for edge and condition detection.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         scl_q <= 1'b1;
         sda_q <= 1'b1;
      end else begin
         scl_q <= scl_s;
         sda_q <= sda_s;
      end
   end

   assign scl_rise   = scl_s & ~scl_q;
   assign scl_fall   = ~scl_s & scl_q;
   assign start_det  = scl_s & scl_q & sda_q & ~sda_s;
   assign stop_det   = scl_s & scl_q & ~sda_q & sda_s;

   assign byte_done  = (bit_cnt == 4'd8);
   assign addr_match = (rx_shift[7:1] == DEV_ADDR);
   assign rw_bit     = rx_shift[0];
   assign ptr_inc    = ptr + ADDR_W'(1);
   assign rd_cur     = regs[ptr];
   assign rd_next    = regs[ptr_inc];

   // State register; reset drops the block back to IDLE immediately.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic; START and STOP override every state.
   always_comb begin
      state_next = state;
      if (start_det) begin
         state_next = ST_ADDR;
      end else if (stop_det) begin
         state_next = ST_IDLE;
      end else begin
         case (state)
            ST_ADDR:      if (scl_fall && byte_done) state_next = addr_match ? ST_ADDR_ACK : ST_IGNORE;
            ST_ADDR_ACK:  if (scl_fall) state_next = rw_bit ? ST_RDATA : ST_PTR;
            ST_PTR:       if (scl_fall && byte_done) state_next = ST_PTR_ACK;
            ST_PTR_ACK:   if (scl_fall) state_next = ST_WDATA;
            ST_WDATA:     if (scl_fall && byte_done) state_next = ST_WDATA_ACK;
            ST_WDATA_ACK: if (scl_fall) state_next = ST_WDATA;
            ST_RDATA:     if (scl_fall && byte_done) state_next = ST_RDATA_ACK;
            ST_RDATA_ACK: begin
               if (scl_rise && sda_s) begin
                  state_next = ST_IDLE;
               end else if (scl_fall) begin
                  state_next = ST_RDATA;
               end
            end
            default:      state_next = state;
         endcase
      end
   end

   // Datapath controls; SDA only ever changes on a detected SCL fall.
   always_comb begin
      sda_oe_next = sda_oe;
      busy_next   = busy;
      rx_bit      = 1'b0;
      tx_bit      = 1'b0;
      clr_cnt     = 1'b0;
      load_ptr    = 1'b0;
      inc_ptr     = 1'b0;
      load_tx     = 1'b0;
      shift_tx    = 1'b0;
      tx_load     = rd_cur;
      do_write    = 1'b0;
      if (start_det) begin
         sda_oe_next = 1'b0;
         clr_cnt     = 1'b1;
      end else if (stop_det) begin
         sda_oe_next = 1'b0;
         busy_next   = 1'b0;
         clr_cnt     = 1'b1;
      end else if (is_rx_state(state)) begin
         if (scl_rise && !byte_done) begin
            rx_bit = 1'b1;
         end
         if (scl_fall && byte_done) begin
            clr_cnt = 1'b1;
            if (state == ST_ADDR) begin
               busy_next   = addr_match;
               sda_oe_next = addr_match;
            end else begin
               sda_oe_next = 1'b1;
               load_ptr    = (state == ST_PTR);
               do_write    = (state == ST_WDATA);
            end
         end
      end else begin
         case (state)
            ST_ADDR_ACK: begin
               if (scl_fall) begin
                  if (rw_bit) begin
                     load_tx     = 1'b1;
                     tx_load     = rd_cur;
                     sda_oe_next = ~rd_cur[7];
                  end else begin
                     sda_oe_next = 1'b0;
                  end
               end
            end
            ST_PTR_ACK: begin
               if (scl_fall) sda_oe_next = 1'b0;
            end
            ST_WDATA_ACK: begin
               if (scl_fall) begin
                  sda_oe_next = 1'b0;
                  inc_ptr     = 1'b1;
               end
            end
            ST_RDATA: begin
               if (scl_rise && !byte_done) begin
                  tx_bit = 1'b1;
               end
               if (scl_fall) begin
                  if (byte_done) begin
                     sda_oe_next = 1'b0;
                     clr_cnt     = 1'b1;
                  end else if (bit_cnt != 4'd0) begin
                     shift_tx    = 1'b1;
                     sda_oe_next = ~tx_shift[6];
                  end
               end
            end
            ST_RDATA_ACK: begin
               if (scl_fall && !(scl_rise && sda_s)) begin
                  inc_ptr     = 1'b1;
                  load_tx     = 1'b1;
                  tx_load     = rd_next;
                  sda_oe_next = ~rd_next[7];
                  clr_cnt     = 1'b1;
               end
            end
            default: begin
               sda_oe_next = sda_oe;
            end
         endcase
      end
   end

   // Bit counter, shifters, pointer, SDA driver and write strobe.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bit_cnt   <= 4'd0;
         rx_shift  <= 8'd0;
         tx_shift  <= 7'd0;
         ptr       <= '0;
         sda_oe    <= 1'b0;
         busy      <= 1'b0;
         wr_strobe <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= 8'd0;
      end else begin
         sda_oe    <= sda_oe_next;
         busy      <= busy_next;
         wr_strobe <= do_write;
         if (clr_cnt) begin
            bit_cnt <= 4'd0;
         end else if (rx_bit || tx_bit) begin
            bit_cnt <= bit_cnt + 4'd1;
         end
         if (rx_bit) begin
            rx_shift <= {rx_shift[6:0], sda_s};
         end
         if (load_ptr) begin
            ptr <= rx_shift[ADDR_W-1:0];
         end else if (inc_ptr) begin
            ptr <= ptr_inc;
         end
         if (load_tx) begin
            tx_shift <= tx_load[6:0];
         end else if (shift_tx) begin
            tx_shift <= {tx_shift[5:0], 1'b0};
         end
         if (do_write) begin
            wr_addr <= ptr;
            wr_data <= rx_shift;
         end
      end
   end

   // Register file and registered host read port; a same-cycle bus write
   // is not forwarded, so the host sees the old value.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= 8'd0;
         end
         host_rdata <= 8'd0;
      end else begin
         host_rdata <= regs[host_raddr];
         if (do_write) begin
            regs[ptr] <= rx_shift;
         end
      end
   end

endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: bus-master driven bench for i2c_target with a
// transaction-level model of the register file and pointer.
module tb_i2c_target;
   import i2c_target_pkg::*;

   localparam int Q = 5;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       scl_m, sda_m;
   logic       sda_bus;
   logic       sda_oe;
   logic [3:0] host_raddr;
   logic [7:0] host_rdata;
   logic       wr_strobe;
   logic [3:0] wr_addr;
   logic [7:0] wr_data;
   logic       busy;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [7:0]  model_regs [16];
   int          model_ptr;
   logic [7:0]  wdata_q [$];
   logic [11:0] strobe_q [$];
   logic [11:0] exp_q [$];

   assign sda_bus = sda_m & ~sda_oe;

   always #5 clk = ~clk;

   i2c_target dut (
      .clk        (clk),
      .reset      (rst_n),
      .scl_in     (scl_m),
      .sda_in     (sda_bus),
      .sda_oe     (sda_oe),
      .host_raddr (host_raddr),
      .host_rdata (host_rdata),
      .wr_strobe  (wr_strobe),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .busy       (busy)
   );

   // Record every write strobe seen on the host side.
   always @(negedge clk) begin
      if (rst_n && wr_strobe) strobe_q.push_back({wr_addr, wr_data});
   end

   task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      tests_run++;
      assert (observed === expected) else begin
         tests_failed++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic quarter();
      repeat (Q) @(negedge clk);
   endtask

   task automatic clock_bit(input logic drive, output logic sampled);
      sda_m = drive;
      quarter();
      scl_m = 1'b1;
      quarter();
      sampled = sda_bus;
      quarter();
      scl_m = 1'b0;
      quarter();
   endtask

   task automatic i2c_start();
      sda_m = 1'b1;
      quarter();
      scl_m = 1'b1;
      quarter();
      sda_m = 1'b0;
      quarter();
      scl_m = 1'b0;
      quarter();
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0;
      quarter();
      scl_m = 1'b1;
      quarter();
      sda_m = 1'b1;
      quarter();
      quarter();
   endtask

   task automatic send_byte(input logic [7:0] b, output logic ack);
      logic dummy;
      for (int i = 7; i >= 0; i--) clock_bit(b[i], dummy);
      clock_bit(1'b1, ack);
   endtask

   task automatic recv_byte(input logic master_ack, output logic [7:0] b);
      logic bit_v;
      for (int i = 7; i >= 0; i--) begin
         clock_bit(1'b1, bit_v);
         b[i] = bit_v;
      end
      clock_bit(master_ack, bit_v);
   endtask

   task automatic host_check(input string tag, input int a);
      host_raddr = 4'(a);
      @(posedge clk);
      @(negedge clk);
      check_output(tag, 32'(host_rdata), 32'(model_regs[a]));
   endtask

   task automatic check_strobes(input string tag);
      check_output({tag, "_strobe_count"}, 32'(strobe_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < strobe_q.size(); i++)
         check_output($sformatf("%s_strobe%0d", tag, i), 32'(strobe_q[i]), 32'(exp_q[i]));
   endtask

   // Pointer byte then the bytes in wdata_q; model writes and advances.
   task automatic write_txn(input string tag, input logic [7:0] ptr_byte);
      logic ack;
      strobe_q.delete();
      exp_q.delete();
      i2c_start();
      send_byte({DEFAULT_DEV_ADDR, 1'b0}, ack);
      check_output({tag, "_addr_ack"}, 32'(ack), 32'd0);
      check_output({tag, "_busy"}, 32'(busy), 32'd1);
      send_byte(ptr_byte, ack);
      check_output({tag, "_ptr_ack"}, 32'(ack), 32'd0);
      model_ptr = ptr_byte % 16;
      foreach (wdata_q[i]) begin
         send_byte(wdata_q[i], ack);
         check_output($sformatf("%s_data_ack%0d", tag, i), 32'(ack), 32'd0);
         model_regs[model_ptr] = wdata_q[i];
         exp_q.push_back({4'(model_ptr), wdata_q[i]});
         model_ptr = (model_ptr + 1) % 16;
      end
      i2c_stop();
      check_strobes(tag);
      check_output({tag, "_busy_after_stop"}, 32'(busy), 32'd0);
   endtask

   // Pointer write, repeated START, then n reads, NACKing the last.
   task automatic read_txn(input string tag, input logic [7:0] ptr_byte, input int n);
      logic       ack;
      logic [7:0] got;
      strobe_q.delete();
      i2c_start();
      send_byte({DEFAULT_DEV_ADDR, 1'b0}, ack);
      send_byte(ptr_byte, ack);
      model_ptr = ptr_byte % 16;
      i2c_start();
      send_byte({DEFAULT_DEV_ADDR, 1'b1}, ack);
      check_output({tag, "_raddr_ack"}, 32'(ack), 32'd0);
      for (int i = 0; i < n; i++) begin
         recv_byte((i == n - 1), got);
         check_output($sformatf("%s_byte%0d", tag, i), 32'(got), 32'(model_regs[model_ptr]));
         if (i < n - 1) model_ptr = (model_ptr + 1) % 16;
      end
      check_output({tag, "_idle_after_nack"}, 32'(dut.state), 32'(ST_IDLE));
      check_output({tag, "_sda_released"}, 32'(sda_oe), 32'd0);
      i2c_stop();
      check_output({tag, "_no_strobe"}, 32'(strobe_q.size()), 32'd0);
   endtask

   initial begin
      logic ack;
      logic dummy;
      rst_n      = 1'b0;
      scl_m      = 1'b1;
      sda_m      = 1'b1;
      host_raddr = 4'd0;
      model_ptr  = 0;
      for (int i = 0; i < 16; i++) model_regs[i] = 8'd0;
      repeat (3) @(negedge clk);
      check_output("rst_sda_oe", 32'(sda_oe), 32'd0);
      check_output("rst_busy", 32'(busy), 32'd0);
      check_output("rst_wr_strobe", 32'(wr_strobe), 32'd0);
      check_output("rst_wr_addr", 32'(wr_addr), 32'd0);
      check_output("rst_wr_data", 32'(wr_data), 32'd0);
      check_output("rst_host_rdata", 32'(host_rdata), 32'd0);
      rst_n = 1'b1;
      quarter();

      // Basic write of two bytes from pointer 2.
      wdata_q = '{8'hA5, 8'h5A};
      write_txn("wr_basic", 8'h02);
      host_check("host_reg2", 2);

      // Pointer wrap during a write burst.
      wdata_q = '{8'h11, 8'h22};
      write_txn("wr_wrap", 8'h0F);
      host_check("host_reg15", 15);
      host_check("host_reg0", 0);

      // Repeated-start read of two bytes.
      read_txn("rd_basic", 8'h02, 2);

      // Foreign address is not acknowledged and never marks busy.
      strobe_q.delete();
      i2c_start();
      send_byte({7'h50, 1'b0}, ack);
      check_output("foreign_nack", 32'(ack), 32'd1);
      check_output("foreign_busy", 32'(busy), 32'd0);
      send_byte(8'h77, ack);
      check_output("foreign_busy2", 32'(busy), 32'd0);
      i2c_stop();
      check_output("foreign_no_strobe", 32'(strobe_q.size()), 32'd0);

      // STOP after four data bits discards the partial byte.
      strobe_q.delete();
      i2c_start();
      send_byte({DEFAULT_DEV_ADDR, 1'b0}, ack);
      send_byte(8'h05, ack);
      model_ptr = 5;
      for (int i = 0; i < 4; i++) clock_bit(1'b1, dummy);
      i2c_stop();
      check_output("partial_no_strobe", 32'(strobe_q.size()), 32'd0);
      check_output("partial_sda_oe", 32'(sda_oe), 32'd0);
      host_check("partial_reg5", 5);

      // Random write and read transactions against the model.
      for (int t = 0; t < 6; t++) begin
         int n;
         n = int'($urandom_range(1, 4));
         wdata_q.delete();
         for (int i = 0; i < n; i++) wdata_q.push_back(8'($urandom_range(0, 255)));
         write_txn($sformatf("rnd_wr%0d", t), 8'($urandom_range(0, 255)));
         read_txn($sformatf("rnd_rd%0d", t), 8'($urandom_range(0, 255)), int'($urandom_range(1, 3)));
      end
      for (int a = 0; a < 16; a++) host_check($sformatf("final_reg%0d", a), a);

      // Reset while the block drives SDA low in a read.
      wdata_q = '{8'h12};
      write_txn("wr_pre_reset", 8'h07);
      i2c_start();
      send_byte({DEFAULT_DEV_ADDR, 1'b0}, ack);
      send_byte(8'h07, ack);
      i2c_start();
      send_byte({DEFAULT_DEV_ADDR, 1'b1}, ack);
      check_output("mid_read_driving", 32'(sda_oe), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_output("abort_sda_oe", 32'(sda_oe), 32'd0);
      check_output("abort_busy", 32'(busy), 32'd0);
      check_output("abort_wr_strobe", 32'(wr_strobe), 32'd0);
      check_output("abort_wr_addr", 32'(wr_addr), 32'd0);
      check_output("abort_wr_data", 32'(wr_data), 32'd0);
      check_output("abort_host_rdata", 32'(host_rdata), 32'd0);
      check_output("abort_state", 32'(dut.state), 32'(ST_IDLE));
      for (int i = 0; i < 16; i++) model_regs[i] = 8'd0;
      model_ptr = 0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      quarter();
      scl_m = 1'b1;
      quarter();
      sda_m = 1'b1;
      quarter();
      host_check("post_reset_reg7", 7);

      // Block works normally again after the abort.
      wdata_q = '{8'h77};
      write_txn("wr_recover", 8'h01);
      host_check("recover_reg1", 1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
